// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus scheduler: FSM encoding, default timing
// constants, HD44780 command codes and the long-execution command decode.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } state_t;

  localparam int T_SETUP_DEF     = 4;
  localparam int T_EPW_DEF       = 25;
  localparam int T_HOLD_DEF      = 4;
  localparam int T_EXEC_DEF      = 2000;
  localparam int T_EXEC_LONG_DEF = 80000;
  localparam int CW_DEF          = 17;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_LINE2     = 8'hC0;
  localparam logic [7:0] CMD_SHL       = 8'h18;

  // Clear (0x01) and home (0x02/0x03) are the only instructions needing the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (!rs && (d[7:2] == 6'd0) && (d != 8'd0));
  endfunction

endpackage

// File: rtl/lcd1602_bus_sched_if.sv
// Requester-side byte handshake for both ports of the LCD bus scheduler.
// valid/ready: a byte transfers on the rising edge where valid and ready are both high;
// ready is only raised while the scheduler is idle, and valid/rs/data are ignored otherwise.
interface lcd1602_bus_sched_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;

  modport master (
    output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter: on contention the port not served last wins;
// the pointer only moves when a grant is actually consumed (advance).
module lcd_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic       grant,
  output logic       any
);

  logic last_q;

  always_comb begin
    any = |valid;
    if (valid == 2'b11) grant = ~last_q;
    else                grant = valid[1];
  end

  // Reset to "last served 1" so port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_q <= 1'b1;
    else if (advance) last_q <= grant;
  end

endmodule

// File: rtl/lcd1602_bus_sched.sv
// Shares one HD44780 parallel bus between two byte requesters, issuing each byte
// with counted RS/data setup, E pulse, hold and post-write execution wait.
module lcd1602_bus_sched
  import lcd1602_pkg::*;
#(
  parameter int T_SETUP     = T_SETUP_DEF,
  parameter int T_EPW       = T_EPW_DEF,
  parameter int T_HOLD      = T_HOLD_DEF,
  parameter int T_EXEC      = T_EXEC_DEF,
  parameter int T_EXEC_LONG = T_EXEC_LONG_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd1602_bus_sched_if.slave    req,
  output logic                  lcd_e,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic [7:0]            data,
  output logic                  busy,
  output logic                  grant_id,
  output state_t                state_dbg
);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            long_q;
  logic            arb_grant, arb_any;
  logic            accept, last;
  logic            sel_rs;
  logic [7:0]      sel_data;

  lcd_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req.req1_valid, req.req0_valid}),
    .advance (accept),
    .grant   (arb_grant),
    .any     (arb_any)
  );

  assign accept         = (state_q == ST_IDLE) && arb_any;
  assign req.req0_ready = accept && !arb_grant;
  assign req.req1_ready = accept &&  arb_grant;
  assign sel_rs         = arb_grant ? req.req1_rs   : req.req0_rs;
  assign sel_data       = arb_grant ? req.req1_data : req.req0_data;
  assign last           = (cnt_q == CW'(1));
  assign busy           = (state_q != ST_IDLE);
  assign state_dbg      = state_q;

  // Each timed state loads its own count on entry and exits when the count reaches 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(T_SETUP);
        end
      end
      ST_SETUP: begin
        if (last) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(T_EPW);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (last) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(T_HOLD);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (last) begin
          state_d = ST_EXEC;
          cnt_d   = long_q ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_EXEC: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // E is registered from the next state so it is high for exactly the PULSE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      data     <= 8'd0;
      grant_id <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      lcd_e  <= (state_d == ST_PULSE);
      lcd_rw <= 1'b0;
      if (accept) begin
        lcd_rs   <= sel_rs;
        data     <= sel_data;
        grant_id <= arb_grant;
        long_q   <= is_long_cmd(sel_rs, sel_data);
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_sched.sv
// Directed bench for lcd1602_bus_sched with shortened timing (2/3/2/5/20 cycles).
module tb_lcd1602_bus_sched;
  import lcd1602_pkg::*;

  localparam int LAT   = 12;  // 2 + 3 + 2 + 5
  localparam int LAT_L = 27;  // 2 + 3 + 2 + 20

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw, busy, grant_id;
  logic [7:0] data;
  state_t     state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic       r1_seen = 1'b0;

  lcd1602_bus_sched_if bus ();

  lcd1602_bus_sched #(
    .T_SETUP(2), .T_EPW(3), .T_HOLD(2), .T_EXEC(5), .T_EXEC_LONG(20), .CW(17)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (bus),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .data      (data),
    .busy      (busy),
    .grant_id  (grant_id),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) if (mon_en && bus.req1_ready) r1_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for a ready, checks which port is offered, then takes the accept edge.
  task automatic do_accept(input string tag, input int port, input logic rs, input logic [7:0] d);
    bit got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_ready_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_ready0"}, 32'(bus.req0_ready), 32'(port == 0));
      check({tag, "_ready1"}, 32'(bus.req1_ready), 32'(port == 1));
      tick();
      check({tag, "_data"}, 32'(data), 32'(d));
      check({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
      check({tag, "_grant"}, 32'(grant_id), 32'(port));
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  // Observes one transaction from the slot after the accept edge until it returns to idle.
  task automatic watch(input string tag, input int lat, input logic rs, input logic [7:0] d);
    int   e_cnt = 0, e_first = -1, rises = 0, busy_cnt = 0, bad = 0;
    logic prev_e = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (lcd_e) begin
        if (e_first < 0) e_first = i;
        e_cnt++;
        if (!prev_e) rises++;
      end
      prev_e = lcd_e;
      if (busy) busy_cnt++;
      if (data !== d || lcd_rs !== rs || lcd_rw !== 1'b0) bad++;
      tick();
    end
    check({tag, "_e_cycles"}, 32'(e_cnt), 32'd3);
    check({tag, "_e_first"}, 32'(e_first), 32'd2);
    check({tag, "_e_rises"}, 32'(rises), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
    check({tag, "_bus_stable"}, 32'(bad), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_e"}, 32'(lcd_e), 32'd0);
  endtask

  task automatic send(input string tag, input int port, input logic rs, input logic [7:0] d,
                      input int lat);
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_rs = rs; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_rs = rs; bus.req1_data = d;
    end
    do_accept(tag, port, rs, d);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    watch(tag, lat, rs, d);
  endtask

  initial begin
    int e_seen, nz;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_rs = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_rs = 1'b0; bus.req1_data = 8'h00;

    // 1: reset then idle with no requests
    repeat (3) tick();
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    e_seen = 0; nz = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lcd_e) e_seen++;
      if (lcd_rs || lcd_rw || data != 8'd0 || busy || grant_id ||
          bus.req0_ready || bus.req1_ready) nz++;
    end
    check("idle_e_toggles", 32'(e_seen), 32'd0);
    check("idle_outputs_zero", 32'(nz), 32'd0);

    // 2: normal instruction
    send("func38", 0, 1'b0, CMD_FUNC_8B2L, LAT);

    // 3: long-exec decode boundaries
    send("clear", 0, 1'b0, CMD_CLEAR, LAT_L);
    send("home02", 0, 1'b0, CMD_HOME, LAT_L);
    send("home03", 0, 1'b0, 8'h03, LAT_L);
    send("cmd04", 0, 1'b0, 8'h04, LAT);
    send("data01", 1, 1'b1, 8'h01, LAT);

    // 4: both valid continuously -> alternation starting at port 0
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h41;
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h42;
    for (int k = 0; k < 4; k++) begin
      do_accept($sformatf("rr%0d", k), k % 2, 1'b1, (k % 2 == 0) ? 8'h41 : 8'h42);
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      watch($sformatf("rr%0d", k), LAT, 1'b1, (k % 2 == 0) ? 8'h41 : 8'h42);
    end

    // 5: async reset mid-pulse; pending request re-accepted, pointer back to port 0
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b0; bus.req0_data = CMD_FUNC_8B2L;
    do_accept("pre_rst", 0, 1'b0, CMD_FUNC_8B2L);
    tick();
    tick();
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h42;
    check("pre_rst_e_high", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_e_drop", 32'(lcd_e), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bus_data", 32'(data), 32'd0);
    tick();
    rst = 1'b0;
    do_accept("post_rst", 0, 1'b0, CMD_FUNC_8B2L);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    watch("post_rst", LAT, 1'b0, CMD_FUNC_8B2L);

    // 6: req1 valid only during EXEC -> ignored
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b0; bus.req0_data = CMD_ENTRY;
    do_accept("entry", 0, 1'b0, CMD_ENTRY);
    bus.req0_valid = 1'b0;
    mon_en = 1'b1;
    repeat (8) tick();
    check("exec_state", 32'(state_dbg), 32'(ST_EXEC));
    bus.req1_valid = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h99;
    #1;
    check("exec_ready1_a", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req1_data = 8'h5A;
    #1;
    check("exec_ready1_b", 32'(bus.req1_ready), 32'd0);
    bus.req1_valid = 1'b0;
    repeat (3) tick();
    check("drop_idle", 32'(busy), 32'd0);
    check("drop_data", 32'(data), 32'(CMD_ENTRY));
    check("drop_rs", 32'(lcd_rs), 32'd0);
    repeat (3) tick();
    check("drop_no_accept", 32'(busy), 32'd0);
    check("drop_r1_never", 32'(r1_seen), 32'd0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
